// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit
//   Instruction prefetcher. Keeps a fetch PC, one outstanding memory read
//   and a DEPTH-entry queue of {pc, inst} pairs that feeds the core.
//   A new read is issued only when the queue has room for every word that
//   has been requested, so a returning word always finds a free slot.
//
//   Optional feature: define FETCH_HALT_EN to make the word 9'h1FF stop
//   fetching (halted = 1) until the next redirect. Without the macro,
//   9'h1FF is an ordinary instruction and halted is tied low.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active low
//   imem_req     read request this cycle
//   imem_addr    read address (always shows fetch_pc)
//   imem_rdata   read data, valid one cycle after an accepted request
//   redirect     flush the queue and restart fetching at redirect_pc
//   redirect_pc  restart address
//   inst         queue-head instruction (0 when empty)
//   inst_pc      queue-head address (0 when empty)
//   inst_valid   queue head valid
//   inst_ready   core takes the head this cycle
//   halted       fetching stopped by a halt word
module fetch_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic [8:0] imem_rdata,
    input  logic       redirect,
    input  logic [7:0] redirect_pc,
    output logic [8:0] inst,
    output logic [7:0] inst_pc,
    output logic       inst_valid,
    input  logic       inst_ready,
    output logic       halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [7:0]    fetch_pc;
    logic [7:0]    inflight_pc;
    logic          inflight;
    logic          halt_q;

    logic          credit_ok;
    logic          issue;
    logic          push;
    logic          pop;
    logic          halt_hit;
    logic [16:0]   head;

    always_comb begin
        credit_ok = (count + CW'(inflight)) < CW'(DEPTH);
        pop       = (count != '0) && inst_ready && !redirect;
`ifdef FETCH_HALT_EN
        // Responses arriving while halted belong to requests issued before
        // the halt word landed; they are dropped.
        push      = inflight && !redirect && !halt_q;
        // Block the request in the same cycle the halt word returns, so no
        // address past the halt word is ever read.
        halt_hit  = push && (imem_rdata == 9'h1FF);
        issue     = rst && credit_ok && !redirect && !halt_q && !halt_hit;
`else
        push      = inflight && !redirect;
        halt_hit  = 1'b0;
        issue     = rst && credit_ok && !redirect;
`endif
    end

    // rst gates the request directly so it drops the instant reset asserts.
    assign imem_req   = issue;
    assign imem_addr  = fetch_pc;

    assign head       = mem[rd_ptr];
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? head[8:0]  : 9'h000;
    assign inst_pc    = inst_valid ? head[16:9] : 8'h00;
    assign halted     = halt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {inflight_pc, imem_rdata};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= 8'h00;
            inflight_pc <= 8'h00;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            halt_q      <= 1'b0;
        end else if (redirect) begin
            // No request is issued during a redirect cycle, so clearing
            // inflight drops the only word that could still return.
            fetch_pc    <= redirect_pc;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            halt_q      <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + 8'd1;
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (halt_hit) begin
                halt_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [8:0] imem_rdata = 9'h000;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic [8:0] inst;
    logic [7:0] inst_pc;
    logic       inst_valid;
    logic       inst_ready = 1'b0;
    logic       halted;

    logic [8:0] rom [256];
    int total = 0;
    int bad   = 0;

    fetch_unit #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency.
    always @(posedge clk) imem_rdata <= imem_req ? rom[imem_addr] : 9'h000;

    task automatic rom_default();
        for (int i = 0; i < 256; i++) rom[i] = 9'(i);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench 1 ns into the first cycle after reset release.
    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; inst_ready = ready;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        total++; if (inst !== 9'h000) begin bad++; $display("FAIL reset_inst: got %h want 000", inst); end
        total++; if (inst_pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", inst_pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stream_req k=%0d: got %b want 1", k, imem_req); end
            total++; if (imem_addr !== 8'(k)) begin bad++; $display("FAIL stream_addr k=%0d: got %h want %h", k, imem_addr, 8'(k)); end
            total++; if (inst_valid !== (k >= 2)) begin bad++; $display("FAIL stream_valid k=%0d: got %b want %b", k, inst_valid, (k >= 2)); end
            if (k >= 2) begin
                total++; if (inst_pc !== 8'(k - 2)) begin bad++; $display("FAIL stream_pc k=%0d: got %h want %h", k, inst_pc, 8'(k - 2)); end
                total++; if (inst !== 9'(k - 2)) begin bad++; $display("FAIL stream_inst k=%0d: got %h want %h", k, inst, 9'(k - 2)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        do_reset(1'b0);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step();
            if (imem_req === 1'b1) begin
                total++; if (imem_addr !== 8'(nreq)) begin bad++; $display("FAIL bp_addr n=%0d: got %h want %h", nreq, imem_addr, 8'(nreq)); end
                nreq++;
            end
        end
        total++; if (nreq !== 4) begin bad++; $display("FAIL bp_nreq: got %0d want 4", nreq); end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00) begin bad++; $display("FAIL bp_head0: got v=%b pc=%h want v=1 pc=00", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            step();
            if (j == 1) begin
                total++; if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin bad++; $display("FAIL bp_resume: got req=%b addr=%h want req=1 addr=04", imem_req, imem_addr); end
            end
            total++; if (inst_valid !== 1'b1 || inst_pc !== 8'(j) || inst !== 9'(j)) begin bad++; $display("FAIL bp_order j=%0d: got v=%b pc=%h inst=%h want v=1 pc=%h", j, inst_valid, inst_pc, inst, 8'(j)); end
        end
    endtask

    task automatic test_full_redirect();
        do_reset(1'b0);
        repeat (6) step();
        redirect = 1'b1; redirect_pc = 8'h20;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fr_req_during: got %b want 0", imem_req); end
        step();
        redirect = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL fr_flush: got %b want 0", inst_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 8'h20) begin bad++; $display("FAIL fr_restart: got req=%b addr=%h want req=1 addr=20", imem_req, imem_addr); end
        repeat (2) step();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h20 || inst !== 9'h020) begin bad++; $display("FAIL fr_head: got v=%b pc=%h inst=%h want v=1 pc=20 inst=020", inst_valid, inst_pc, inst); end
        step();
        total++; if (inst_pc !== 8'h20) begin bad++; $display("FAIL fr_hold: got %h want 20", inst_pc); end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        repeat (5) step();
        total++; if (inst_pc !== 8'h03) begin bad++; $display("FAIL rd_pre: got %h want 03", inst_pc); end
        redirect = 1'b1; redirect_pc = 8'h40;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rd_req_during: got %b want 0", imem_req); end
        step();
        redirect = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rd_flush: got %b want 0", inst_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin bad++; $display("FAIL rd_addr: got req=%b addr=%h want req=1 addr=40", imem_req, imem_addr); end
        step();
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rd_drop: got %b want 0", inst_valid); end
        step();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h40 || inst !== 9'h040) begin bad++; $display("FAIL rd_head: got v=%b pc=%h inst=%h want v=1 pc=40 inst=040", inst_valid, inst_pc, inst); end
        step();
        total++; if (inst_pc !== 8'h41) begin bad++; $display("FAIL rd_next: got %h want 41", inst_pc); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [4];
        exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
        redirect = 1'b1; redirect_pc = 8'hFE;
        step();
        redirect = 1'b0;
        #1;
        total++; if (imem_addr !== 8'hFE) begin bad++; $display("FAIL wrap_addr0: got %h want FE", imem_addr); end
        repeat (2) step();
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL wrap_addr2: got %h want 00", imem_addr); end
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step();
            total++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc[j] || inst !== {1'b0, exp_pc[j]}) begin bad++; $display("FAIL wrap_seq j=%0d: got v=%b pc=%h inst=%h want pc=%h", j, inst_valid, inst_pc, inst, exp_pc[j]); end
        end
    endtask

    task automatic test_halt_word();
        rom[3] = 9'h1FF;
        do_reset(1'b1);
        repeat (2) step();
        for (int j = 0; j < 3; j++) begin
            if (j > 0) step();
            total++; if (inst_pc !== 8'(j)) begin bad++; $display("FAIL halt_pre j=%0d: got %h want %h", j, inst_pc, 8'(j)); end
        end
`ifdef FETCH_HALT_EN
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_noreq4: got %b want 0", imem_req); end
        step();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_set: got %b want 1", halted); end
        total++; if (inst_pc !== 8'h03 || inst !== 9'h1FF) begin bad++; $display("FAIL halt_word: got pc=%h inst=%h want pc=03 inst=1FF", inst_pc, inst); end
        step();
        total++; if (inst_valid !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL halt_idle: got v=%b req=%b h=%b want 0 0 1", inst_valid, imem_req, halted); end
        redirect = 1'b1; redirect_pc = 8'h10;
        step();
        redirect = 1'b0;
        #1;
        total++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h10) begin bad++; $display("FAIL halt_clear: got h=%b req=%b addr=%h want 0 1 10", halted, imem_req, imem_addr); end
        repeat (2) step();
        total++; if (inst_pc !== 8'h10) begin bad++; $display("FAIL halt_refetch: got %h want 10", inst_pc); end
`else
        total++; if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin bad++; $display("FAIL plain_req4: got req=%b addr=%h want 1 04", imem_req, imem_addr); end
        step();
        total++; if (inst_pc !== 8'h03 || inst !== 9'h1FF || halted !== 1'b0) begin bad++; $display("FAIL plain_word: got pc=%h inst=%h h=%b want 03 1FF 0", inst_pc, inst, halted); end
        step();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h04 || halted !== 1'b0) begin bad++; $display("FAIL plain_next: got v=%b pc=%h h=%b want 1 04 0", inst_valid, inst_pc, halted); end
`endif
        rom[3] = 9'h003;
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        repeat (4) step();
        total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL rm_pre: got %b want 1", inst_valid); end
        rst = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL rm_async: got v=%b req=%b want 0 0", inst_valid, imem_req); end
        total++; if (imem_addr !== 8'h00 || inst_pc !== 8'h00 || inst !== 9'h000) begin bad++; $display("FAIL rm_zero: got addr=%h pc=%h inst=%h want 00 00 000", imem_addr, inst_pc, inst); end
        @(negedge clk);
        rst = 1'b1; inst_ready = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL rm_restart: got req=%b addr=%h want 1 00", imem_req, imem_addr); end
        step();
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rm_dropped: got %b want 0", inst_valid); end
        step();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00) begin bad++; $display("FAIL rm_first: got v=%b pc=%h want 1 00", inst_valid, inst_pc); end
    endtask

    initial begin
        rom_default();
        test_reset();
        test_stream();
        test_backpressure();
        test_full_redirect();
        test_redirect();
        test_wrap();
        test_halt_word();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
